// File: rtl/draw_starfield_layers_if.sv
// draw_starfield_layers_if: VGA pixel-stream record and the vga interface that carries it.
package vga_pkg;
  typedef struct packed {
    logic [10:0] pxl_x;
    logic [10:0] pxl_y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
  } vga_t;
endpackage

interface vga;
  vga_pkg::vga_t t;
  modport in (input t);
  modport out (output t);
endinterface

// File: rtl/draw_starfield_layers.sv
// draw_starfield_layers: parallax multi-layer LFSR star field for the VGA background path.
// Define STARS_TWINKLE_EN to halve star intensity on alternating groups of frames.
module draw_starfield_layers #(
  parameter int                WIDTH      = 640,
  parameter int                HEIGHT     = 480,
  parameter int                NUM_LAYERS = 3,
  parameter int                LFSR_W     = 10,
  parameter logic [LFSR_W-1:0] TAPS       = 10'h240,
  parameter logic [LFSR_W-1:0] SEED       = 10'h001,
  parameter logic [LFSR_W-1:0] SEED_STEP  = 10'h0B5,
  parameter int                GAP_BITS   = 4,
  parameter int                MIN_GAP    = 2,
  parameter int                SCROLL_DIV = 4
) (
  input  logic clk,
  input  logic resetN,
  vga.in       i,
  vga.out      o,
  input  logic scroll_en,
  output logic Draw
);
  localparam int CW = LFSR_W + 3;
  localparam int FW = $clog2(SCROLL_DIV + 1);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 4 || MIN_GAP < 1 || SCROLL_DIV < 1 ||
      GAP_BITS > LFSR_W || WIDTH < 1 || HEIGHT < 1) begin : g_bad_cfg
    $error("draw_starfield_layers: illegal parameter set");
  end

  function automatic logic [LFSR_W-1:0] layer_seed(input int n);
    logic [LFSR_W-1:0] s;
    s = SEED + LFSR_W'(n) * SEED_STEP;
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

  logic                  r_armed;
  logic [FW-1:0]         r_frame_cnt;
  vga_pkg::vga_t         r_t;
  logic                  w_fs;
  logic                  w_top;
  logic                  w_scroll;
  logic [NUM_LAYERS-1:0] w_hit;
  logic [3:0]            w_col;
`ifdef STARS_TWINKLE_EN
  logic [7:0]            r_tw;
  logic [NUM_LAYERS-1:0] w_msb;
`endif

  assign w_fs     = i.t.pxl_x == '0 && i.t.pxl_y == '0;
  assign w_top    = r_frame_cnt == FW'(SCROLL_DIV - 1);
  assign w_scroll = w_fs && scroll_en && w_top;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    localparam logic [LFSR_W-1:0] SK = layer_seed(k);
    logic [LFSR_W-1:0] r_lfsr;
    logic [CW-1:0]     r_cnt;
    logic [7:0]        r_off;
    logic [CW-1:0]     w_gap;
    assign w_hit[k] = r_armed && !w_fs && r_cnt == '0;
    assign w_gap    = CW'(MIN_GAP) + (CW'(r_lfsr[GAP_BITS-1:0]) << k);
`ifdef STARS_TWINKLE_EN
    assign w_msb[k] = r_lfsr[LFSR_W-1];
`endif
    // Offsets load the counter at frame start, so a larger offset delays every star of the layer.
    always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
        r_lfsr <= SK;
        r_cnt  <= '0;
        r_off  <= '0;
      end else if (w_fs) begin
        r_lfsr <= SK;
        r_cnt  <= CW'(r_off);
        if (w_scroll) r_off <= r_off + 8'(NUM_LAYERS - k);
      end else if (r_armed) begin
        r_cnt <= (r_cnt == '0) ? w_gap : r_cnt - 1'b1;
        if (r_cnt == '0) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
      end
  end

  // Highest layer index first so the nearest hitting layer overwrites.
  always_comb begin
    w_col = '0;
    for (int j = NUM_LAYERS - 1; j >= 0; j--)
      if (w_hit[j])
`ifdef STARS_TWINKLE_EN
        w_col = (w_msb[j] ^ r_tw[j + 3]) ? 4'hF >> (j + 1) : 4'hF >> j;
`else
        w_col = 4'hF >> j;
`endif
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_armed     <= 1'b0;
      r_frame_cnt <= '0;
      r_t         <= '0;
      Draw        <= 1'b0;
    end else begin
      if (w_fs) r_armed <= 1'b1;
      if (w_fs) r_frame_cnt <= w_top ? (scroll_en ? '0 : r_frame_cnt) : r_frame_cnt + 1'b1;
      r_t       <= i.t;
      r_t.red   <= w_col;
      r_t.green <= w_col;
      r_t.blue  <= w_col;
      Draw      <= |w_hit;
    end

`ifdef STARS_TWINKLE_EN
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_tw <= '0;
    else if (w_fs) r_tw <= r_tw + 1'b1;
`endif

  assign o.t = r_t;
endmodule

// File: tb/tb_draw_starfield_layers.sv
// tb_draw_starfield_layers: random pixel streams checked against a star-position model.
module tb_draw_starfield_layers;
  localparam int N = 3;
  localparam int SDIV = 4;
  localparam int MIN_GAP = 2;
  localparam int GB = 4;
  localparam logic [9:0] TAPS = 10'h240;
  localparam logic [9:0] SEED = 10'h001;
  localparam logic [9:0] STEP = 10'h0B5;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic scroll_en = 1'b0;
  logic Draw;
  bit sc = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [9:0] m_lfsr [N];
  int m_nxt [N];
  int m_off [N];
  int m_since;
  int m_fc;
  bit m_armed;
  logic exp_draw;
  vga_pkg::vga_t exp_t;
  logic obs_d;
  logic [3:0] obs_c;

  vga vin ();
  vga vout ();

  draw_starfield_layers dut (
    .clk(clk),
    .resetN(resetN),
    .i(vin),
    .o(vout),
    .scroll_en(scroll_en),
    .Draw(Draw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] seed_of(input int k);
    logic [9:0] s;
    s = SEED + 10'(k * STEP);
    return (s == 10'd0) ? 10'd1 : s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_lfsr[k] = seed_of(k);
      m_nxt[k] = 0;
      m_off[k] = 0;
    end
    m_since = 0;
    m_fc = 0;
    m_armed = 0;
    exp_draw = 1'b0;
    exp_t = '0;
  endtask

  // Star k appears at offset+1 cycles after frame start, then every gap+1 cycles.
  task automatic drive(input int x, input int y);
    vga_pkg::vga_t t;
    logic [3:0] col;
    t = '0;
    t.pxl_x = 11'(x);
    t.pxl_y = 11'(y);
    {t.hsync, t.vsync, t.de} = 3'($urandom);
    {t.red, t.green, t.blue} = 12'($urandom);
    scroll_en = sc;
    vin.t = t;
    exp_draw = 1'b0;
    col = 4'h0;
    if (x == 0 && y == 0) begin
      for (int k = 0; k < N; k++) begin
        m_lfsr[k] = seed_of(k);
        m_nxt[k] = m_off[k] + 1;
      end
      if (sc && m_fc == SDIV - 1) begin
        for (int k = 0; k < N; k++) m_off[k] = (m_off[k] + N - k) % 256;
        m_fc = 0;
      end else if (m_fc < SDIV - 1) m_fc++;
      m_since = 0;
      m_armed = 1;
    end else if (m_armed) begin
      m_since++;
      for (int k = N - 1; k >= 0; k--)
        if (m_since == m_nxt[k]) begin
          exp_draw = 1'b1;
          col = 4'hF >> k;
          m_nxt[k] = m_since + MIN_GAP + (int'(m_lfsr[k] & 10'((1 << GB) - 1)) << k) + 1;
          m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? TAPS : 10'h0);
        end
    end
    exp_t = t;
    exp_t.red = col;
    exp_t.green = col;
    exp_t.blue = col;
  endtask

  task automatic cyc(input int x, input int y);
    @(negedge clk);
    obs_d = Draw;
    obs_c = vout.t.red;
    check("draw", 64'(Draw), 64'(exp_draw));
    check("pix", 64'(vout.t), 64'(exp_t));
    resetN = 1'b1;
    drive(x, y);
  endtask

  task automatic async_reset();
    #2 resetN = 1'b0;
    #1 check("arst_draw", 64'(Draw), 64'd0);
    check("arst_pix", 64'(vout.t), 64'd0);
    model_reset();
  endtask

  // First frame after reset: hand-derived star timing from seeds 001/0B6/16B.
  task automatic directed();
    for (int n = 0; n < 40; n++) begin
      cyc(n, 0);
      if (n == 1 || n == 3 || n == 7) check("gap_dark", 64'({obs_d, obs_c}), 64'h00);
      if (n == 2 || n == 6 || n == 9) check("l0_star", 64'({obs_d, obs_c}), 64'h1F);
      if (n == 17) check("l1_star", 64'({obs_d, obs_c}), 64'h17);
    end
    for (int n = 0; n < 40; n++) cyc(n, 1);
  endtask

  task automatic frame(input int w, input int h, input int rx, input int ry);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        cyc(x, y);
        if (x == rx && y == ry) async_reset();
      end
  endtask

  initial begin
    vin.t = '0;
    vin.t.pxl_y = 11'd1;
    model_reset();
    repeat (1000) cyc($urandom_range(0, 639), $urandom_range(1, 479));
    sc = 1'b0;
    directed();
    sc = 1'b1;
    repeat (14) frame($urandom_range(24, 64), $urandom_range(2, 4), -1, -1);
    frame(128, 52, 100, 50);
    directed();
    repeat (6) begin
      sc = 1'($urandom);
      frame($urandom_range(24, 64), $urandom_range(2, 4), -1, -1);
    end
    repeat (600) cyc($urandom_range(1, 639), $urandom_range(0, 479));
    sc = 1'b0;
    repeat (6) frame(48, 3, -1, -1);
    @(negedge clk);
    check("draw", 64'(Draw), 64'(exp_draw));
    check("pix", 64'(vout.t), 64'(exp_t));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
